// File: rtl/shift_reg_univ_if.sv
// Bus bundle for the universal shift register: control/data in, register state out.
interface shift_reg_univ_if #(
   parameter int WIDTH = 8,
   parameter int AMT_W = 4
);
   logic             ld;
   logic [WIDTH-1:0] d;
   logic             en;
   logic             dir;
   logic [1:0]       mode;
   logic             sd;
   logic             start;
   logic [AMT_W-1:0] amt;
   logic [WIDTH-1:0] q;
   logic             so;
   logic             busy;
   logic             done;

   modport master (
      output ld, d, en, dir, mode, sd, start, amt,
      input  q, so, busy, done
   );

   modport slave (
      input  ld, d, en, dir, mode, sd, start, amt,
      output q, so, busy, done
   );
endinterface

// File: rtl/shift_reg_univ.sv
// Universal shift register: parallel load, single-step shift, and a counted
// multi-step shift with busy/done handshake. Fill modes: serial, rotate,
// arithmetic, zero.
module shift_reg_univ #(
   parameter int WIDTH = 8,
   parameter int AMT_W = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   shift_reg_univ_if.slave  sr_if
);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic             so_q, so_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [AMT_W-1:0] count_q, count_d;
   logic             dir_q, dir_d;
   logic [1:0]       mode_q, mode_d;

   // Step operands: latched settings during a counted shift, live ones otherwise.
   logic             step_dir;
   logic [1:0]       step_mode;
   logic             expelled;
   logic             fill;
   logic [WIDTH-1:0] shifted;

   // One shift step computed from the current register contents.
   always_comb begin
      step_dir  = (state_q == SHIFT) ? dir_q  : sr_if.dir;
      step_mode = (state_q == SHIFT) ? mode_q : sr_if.mode;
      expelled  = step_dir ? q_q[0] : q_q[WIDTH-1];
      fill      = 1'b0;
      case (step_mode)
         2'b00:   fill = sr_if.sd;
         2'b01:   fill = expelled;
         2'b10:   fill = step_dir ? q_q[WIDTH-1] : 1'b0;
         default: fill = 1'b0;
      endcase
      shifted = step_dir ? {fill, q_q[WIDTH-1:1]} : {q_q[WIDTH-2:0], fill};
   end

   // Next-state: ld > counted step > start > single-step enable.
   always_comb begin
      state_d = state_q;
      q_d     = q_q;
      so_d    = so_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      count_d = count_q;
      dir_d   = dir_q;
      mode_d  = mode_q;
      if (sr_if.ld) begin
         // Load also aborts a counted shift without signalling done.
         q_d     = sr_if.d;
         state_d = IDLE;
         busy_d  = 1'b0;
         count_d = '0;
      end else if (state_q == SHIFT) begin
         q_d     = shifted;
         so_d    = expelled;
         count_d = count_q - AMT_W'(1);
         if (count_q == AMT_W'(1)) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
         end
      end else if (sr_if.start) begin
         if (sr_if.amt != '0) begin
            state_d = SHIFT;
            busy_d  = 1'b1;
            count_d = sr_if.amt;
            dir_d   = sr_if.dir;
            mode_d  = sr_if.mode;
         end else begin
            // Zero-length request completes immediately.
            done_d = 1'b1;
         end
      end else if (sr_if.en) begin
         q_d  = shifted;
         so_d = expelled;
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
         q_q     <= '0;
         so_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         count_q <= '0;
         dir_q   <= 1'b0;
         mode_q  <= 2'b00;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         so_q    <= so_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         count_q <= count_d;
         dir_q   <= dir_d;
         mode_q  <= mode_d;
      end
   end

   assign sr_if.q    = q_q;
   assign sr_if.so   = so_q;
   assign sr_if.busy = busy_q;
   assign sr_if.done = done_q;

endmodule

// File: tb/tb_shift_reg_univ.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// cycle-level behavioural model; a 16-bit instance checks a full rotation.
module tb_shift_reg_univ;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic reset16_n = 1'b0;
   int   n_checks = 0;
   int   n_pass = 0;

   always #5 clk = ~clk;

   shift_reg_univ_if #(.WIDTH(8),  .AMT_W(4)) bus8 ();
   shift_reg_univ_if #(.WIDTH(16), .AMT_W(5)) bus16 ();

   shift_reg_univ #(.WIDTH(8), .AMT_W(4)) dut8 (
      .clk(clk), .reset_n(reset_n), .sr_if(bus8)
   );
   shift_reg_univ #(.WIDTH(16), .AMT_W(5)) dut16 (
      .clk(clk), .reset_n(reset16_n), .sr_if(bus16)
   );

   // Reference model state (8-bit instance).
   logic [7:0] m_q;
   logic       m_so;
   logic       m_done;
   int         m_left;
   logic       m_dir;
   logic [1:0] m_mode;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   // One shift of the model register, written as plain arithmetic.
   task automatic m_step(input logic dir, input logic [1:0] mode, input logic sd);
      logic out_bit, fill_bit;
      out_bit = dir ? m_q[0] : m_q[7];
      case (mode)
         2'd0:    fill_bit = sd;
         2'd1:    fill_bit = out_bit;
         2'd2:    fill_bit = dir ? m_q[7] : 1'b0;
         default: fill_bit = 1'b0;
      endcase
      if (dir) m_q = (m_q >> 1) | {fill_bit, 7'b0};
      else     m_q = (m_q << 1) | {7'b0, fill_bit};
      m_so = out_bit;
   endtask

   // Advance the model by one clock using the inputs seen at this edge.
   task automatic m_update();
      logic nd;
      nd = 1'b0;
      if (!reset_n) begin
         m_q = 8'h00; m_so = 1'b0; m_left = 0; m_dir = 1'b0; m_mode = 2'd0;
      end else if (bus8.ld) begin
         m_q = bus8.d; m_left = 0;
      end else if (m_left > 0) begin
         m_step(m_dir, m_mode, bus8.sd);
         m_left--;
         if (m_left == 0) nd = 1'b1;
      end else if (bus8.start) begin
         if (bus8.amt == 4'd0) nd = 1'b1;
         else begin
            m_left = int'(bus8.amt); m_dir = bus8.dir; m_mode = bus8.mode;
         end
      end else if (bus8.en) begin
         m_step(bus8.dir, bus8.mode, bus8.sd);
      end
      m_done = nd;
   endtask

   // Clock edge, model update, then compare all outputs after the edge.
   task automatic tick();
      @(posedge clk);
      m_update();
      #1;
      chk("q",    32'(bus8.q),    32'(m_q));
      chk("so",   32'(bus8.so),   32'(m_so));
      chk("busy", 32'(bus8.busy), 32'(m_left > 0));
      chk("done", 32'(bus8.done), 32'(m_done));
   endtask

   task automatic idle_inputs();
      bus8.ld = 1'b0; bus8.en = 1'b0; bus8.start = 1'b0;
      bus8.dir = 1'b0; bus8.mode = 2'd0; bus8.sd = 1'b0; bus8.amt = 4'd0;
   endtask

   task automatic load8(input logic [7:0] v);
      bus8.ld = 1'b1; bus8.d = v; tick(); bus8.ld = 1'b0;
   endtask

   initial begin
      int busy_cycles;
      int waited;
      idle_inputs();
      bus8.d = 8'h00;
      m_q = 8'h00; m_so = 1'b0; m_done = 1'b0; m_left = 0; m_dir = 1'b0; m_mode = 2'd0;
      bus16.ld = 1'b0; bus16.d = 16'h0; bus16.en = 1'b0; bus16.dir = 1'b0;
      bus16.mode = 2'd0; bus16.sd = 1'b0; bus16.start = 1'b0; bus16.amt = 5'd0;
      tick();

      // Reset overrides a pending load.
      reset_n = 1'b1;
      load8(8'hA5);
      chk("load_a5", 32'(bus8.q), 32'h A5);
      bus8.ld = 1'b1; bus8.d = 8'hA5; reset_n = 1'b0; tick();
      bus8.ld = 1'b0; reset_n = 1'b1;
      chk("rst_q", 32'(bus8.q), 32'h0);
      chk("rst_so", 32'(bus8.so), 32'h0);
      chk("rst_busy", 32'(bus8.busy), 32'h0);
      chk("rst_done", 32'(bus8.done), 32'h0);
      $display("txn reset: q=%02h", bus8.q);

      // Load and single steps.
      load8(8'b1001_0110);
      bus8.en = 1'b1; bus8.dir = 1'b1; bus8.mode = 2'd0; bus8.sd = 1'b1; tick();
      chk("step_r_q", 32'(bus8.q), 32'h CB);
      chk("step_r_so", 32'(bus8.so), 32'h0);
      bus8.dir = 1'b0; bus8.sd = 1'b0; tick();
      chk("step_l_q", 32'(bus8.q), 32'h96);
      chk("step_l_so", 32'(bus8.so), 32'h1);
      idle_inputs();
      $display("txn single steps: q=%02h so=%0b", bus8.q, bus8.so);

      // Arithmetic right by 3.
      load8(8'h80);
      bus8.start = 1'b1; bus8.amt = 4'd3; bus8.dir = 1'b1; bus8.mode = 2'd2; tick();
      idle_inputs();
      chk("asr_busy_on", 32'(bus8.busy), 32'h1);
      tick(); tick(); tick();
      chk("asr_q", 32'(bus8.q), 32'h F0);
      chk("asr_so", 32'(bus8.so), 32'h0);
      chk("asr_done", 32'(bus8.done), 32'h1);
      chk("asr_busy_off", 32'(bus8.busy), 32'h0);
      tick();
      chk("asr_done_clr", 32'(bus8.done), 32'h0);
      $display("txn arith right: q=%02h", bus8.q);

      // Arithmetic left by 1.
      load8(8'h81);
      bus8.start = 1'b1; bus8.amt = 4'd1; bus8.dir = 1'b0; bus8.mode = 2'd2; tick();
      idle_inputs();
      tick();
      chk("asl_q", 32'(bus8.q), 32'h02);
      chk("asl_so", 32'(bus8.so), 32'h1);
      chk("asl_done", 32'(bus8.done), 32'h1);
      $display("txn arith left: q=%02h", bus8.q);

      // Rotate left by 8 with start/en/dir/mode noise mid-run.
      load8(8'h81);
      bus8.start = 1'b1; bus8.amt = 4'd8; bus8.dir = 1'b0; bus8.mode = 2'd1; tick();
      for (int i = 0; i < 7; i++) begin
         bus8.start = 1'($urandom_range(1)); bus8.en = 1'($urandom_range(1));
         bus8.dir = 1'($urandom_range(1)); bus8.mode = 2'($urandom_range(3));
         bus8.amt = 4'($urandom_range(15));
         tick();
         chk("rot_busy", 32'(bus8.busy), 32'h1);
      end
      idle_inputs();
      tick();
      chk("rot_q", 32'(bus8.q), 32'h81);
      chk("rot_done", 32'(bus8.done), 32'h1);
      tick();
      chk("rot_done_once", 32'(bus8.done), 32'h0);
      $display("txn rotate 8: q=%02h", bus8.q);

      // Abort by load on the second step.
      bus8.start = 1'b1; bus8.amt = 4'd5; bus8.dir = 1'b1; bus8.mode = 2'd3; tick();
      idle_inputs();
      tick();
      bus8.ld = 1'b1; bus8.d = 8'h3C; tick(); bus8.ld = 1'b0;
      chk("abort_q", 32'(bus8.q), 32'h3C);
      chk("abort_busy", 32'(bus8.busy), 32'h0);
      chk("abort_done", 32'(bus8.done), 32'h0);
      tick();
      chk("abort_done2", 32'(bus8.done), 32'h0);
      $display("txn abort: q=%02h", bus8.q);

      // Zero-length counted shift.
      bus8.start = 1'b1; bus8.amt = 4'd0; bus8.dir = 1'b1; bus8.mode = 2'd3; tick();
      idle_inputs();
      chk("amt0_q", 32'(bus8.q), 32'h3C);
      chk("amt0_done", 32'(bus8.done), 32'h1);
      chk("amt0_busy", 32'(bus8.busy), 32'h0);
      tick();
      chk("amt0_done_clr", 32'(bus8.done), 32'h0);
      $display("txn amt0: q=%02h", bus8.q);

      // Reset during a counted shift.
      bus8.start = 1'b1; bus8.amt = 4'd6; bus8.dir = 1'b1; bus8.mode = 2'd0; bus8.sd = 1'b1; tick();
      idle_inputs();
      tick(); tick();
      reset_n = 1'b0; tick(); reset_n = 1'b1;
      chk("midrst_q", 32'(bus8.q), 32'h0);
      chk("midrst_busy", 32'(bus8.busy), 32'h0);
      chk("midrst_done", 32'(bus8.done), 32'h0);
      tick(); tick();
      chk("midrst_done2", 32'(bus8.done), 32'h0);
      $display("txn reset mid-shift: q=%02h", bus8.q);

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         reset_n    = ($urandom_range(99) != 0);
         bus8.ld    = ($urandom_range(15) == 0);
         bus8.d     = 8'($urandom);
         bus8.start = ($urandom_range(7) == 0);
         bus8.amt   = 4'($urandom_range(15));
         bus8.en    = 1'($urandom_range(1));
         bus8.dir   = 1'($urandom_range(1));
         bus8.mode  = 2'($urandom_range(3));
         bus8.sd    = 1'($urandom_range(1));
         tick();
      end
      reset_n = 1'b1;
      idle_inputs();
      $display("txn random: 3000 cycles done");

      // 16-bit instance: rotate right by 16 returns the original word.
      @(posedge clk); #1;
      reset16_n = 1'b1;
      bus16.ld = 1'b1; bus16.d = 16'hA53C;
      @(posedge clk); #1;
      bus16.ld = 1'b0;
      bus16.start = 1'b1; bus16.amt = 5'd16; bus16.dir = 1'b1; bus16.mode = 2'd1;
      @(posedge clk); #1;
      bus16.start = 1'b0;
      busy_cycles = 0;
      waited = 0;
      while (!bus16.done && waited < 40) begin
         if (bus16.busy) busy_cycles++;
         @(posedge clk); #1;
         waited++;
      end
      chk("w16_done_seen", 32'(bus16.done), 32'h1);
      chk("w16_q", 32'(bus16.q), 32'h A53C);
      chk("w16_busy_cycles", 32'(busy_cycles), 32'd16);
      $display("txn w16 rotate: q=%04h busy_cycles=%0d", bus16.q, busy_cycles);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
